// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared CAM geometry, types, drain state enum and bit helpers
package cam_pkg;

    localparam int CAM_DEPTH = 32;
    localparam int CAM_IDX_W = 5;

    typedef logic [CAM_DEPTH-1:0] cam_match_t;
    typedef logic [CAM_IDX_W-1:0] cam_idx_t;
    typedef logic [CAM_IDX_W:0]   cam_cnt_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

    // Descending scan so the lowest set bit wins; returns 0 for an empty vector.
    function automatic cam_idx_t lowest_set(input cam_match_t v);
        cam_idx_t r;
        r = '0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (v[i]) r = cam_idx_t'(i);
        end
        return r;
    endfunction

    function automatic cam_cnt_t popcount(input cam_match_t v);
        cam_cnt_t c;
        c = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            c = c + cam_cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/onehot_dec_5_32.sv
// rtl/onehot_dec_5_32.sv - 5-bit index to 32-bit one-hot decoder
module onehot_dec_5_32
    import cam_pkg::*;
(
    input  cam_idx_t   idx,
    output cam_match_t onehot
);

    assign onehot = cam_match_t'(1) << idx;

endmodule

// File: rtl/cam_match_drain.sv
// rtl/cam_match_drain.sv - drains a CAM match vector as ascending index beats
// Optional MATCH_DRAIN_COUNT_EN adds the out_remaining popcount port.
module cam_match_drain
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  cam_match_t in_match,
    output logic       out_valid,
    input  logic       out_ready,
    output cam_idx_t   out_idx,
    output logic       out_hit,
    output logic       out_last
`ifdef MATCH_DRAIN_COUNT_EN
    ,
    output cam_cnt_t   out_remaining
`endif
);

    drain_state_t state_q, state_d;
    cam_match_t   pending_q, pending_d;
    cam_match_t   clear_mask;
    cam_idx_t     lsb_idx;
    logic         pending_zero;
    logic         pending_single;

    assign lsb_idx        = lowest_set(pending_q);
    assign pending_zero   = (pending_q == '0);
    assign pending_single = !pending_zero && ((pending_q & (pending_q - cam_match_t'(1))) == '0);

    onehot_dec_5_32 u_clear_dec (
        .idx    (lsb_idx),
        .onehot (clear_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DRAIN);
        out_idx   = '0;
        out_hit   = 1'b0;
        out_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pending_d = in_match;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_idx  = lsb_idx;
                out_hit  = !pending_zero;
                // An empty vector still emits one terminating miss beat.
                out_last = pending_zero || pending_single;
                if (out_ready) begin
                    pending_d = pending_q & ~clear_mask;
                    if (out_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d   = ST_IDLE;
            pending_d = '0;
        end
    end

`ifdef MATCH_DRAIN_COUNT_EN
    assign out_remaining = (state_q == ST_DRAIN) ? popcount(pending_q) : '0;
`endif

endmodule

// File: tb/tb_cam_match_drain.sv
// tb/tb_cam_match_drain.sv - scoreboard bench for cam_match_drain
module tb_cam_match_drain;
    import cam_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    cam_match_t in_match = '0;
    logic       in_ready;
    logic       out_valid;
    cam_idx_t   out_idx;
    logic       out_hit;
    logic       out_last;
    cam_cnt_t   out_remaining;

    typedef struct packed {
        logic [4:0] idx;
        logic       hit;
        logic       last;
        logic [5:0] rem;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    cam_match_drain dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_match      (in_match),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_idx       (out_idx),
        .out_hit       (out_hit),
        .out_last      (out_last)
`ifdef MATCH_DRAIN_COUNT_EN
        ,
        .out_remaining (out_remaining)
`endif
    );

`ifndef MATCH_DRAIN_COUNT_EN
    assign out_remaining = '0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_beat(input int idx, input logic hit, input logic last, input int rem);
        beat_t b;
        b.idx  = 5'(idx);
        b.hit  = hit;
        b.last = last;
        b.rem  = 6'(rem);
        exp_q.push_back(b);
    endtask

    // Expected beats for a full drain, counted by hand-rule: ascending set bits.
    task automatic push_vector(input cam_match_t v);
        int left;
        left = 0;
        for (int i = 0; i < CAM_DEPTH; i++) if (v[i]) left++;
        if (left == 0) begin
            push_beat(0, 1'b0, 1'b1, 0);
        end else begin
            for (int i = 0; i < CAM_DEPTH; i++) begin
                if (v[i]) begin
                    push_beat(i, 1'b1, left == 1, left);
                    left--;
                end
            end
        end
    endtask

    task automatic send(input cam_match_t v);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_match = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain(input logic toggle);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
            t++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && out_valid) begin
            if (exp_q.size() == 0) begin
                if (out_ready) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got idx %0d hit %0b last %0b expected no beat", out_idx, out_hit, out_last);
                end
            end else begin
                check("beat_idx", 32'(out_idx), 32'(exp_q[0].idx));
                check("beat_hit", 32'(out_hit), 32'(exp_q[0].hit));
                check("beat_last", 32'(out_last), 32'(exp_q[0].last));
`ifdef MATCH_DRAIN_COUNT_EN
                check("beat_remaining", 32'(out_remaining), 32'(exp_q[0].rem));
`endif
                check("in_ready_during_drain", 32'(in_ready), 32'd0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_hit", 32'(out_hit), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_remaining", 32'(out_remaining), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Three sparse hits, last on the top entry.
        push_vector(32'h8000_0011);
        send(32'h8000_0011);
        wait_drain(1'b0);
        check("t1_in_ready_after_last", 32'(in_ready), 32'd1);
        check("t1_out_valid_after_last", 32'(out_valid), 32'd0);

        // Empty vector yields one miss beat.
        push_vector(32'h0);
        send(32'h0);
        wait_drain(1'b0);
        check("t2_idle_in_ready", 32'(in_ready), 32'd1);

        // All ones under alternating backpressure.
        push_vector(32'hFFFF_FFFF);
        send(32'hFFFF_FFFF);
        wait_drain(1'b1);
        check("t3_idle_in_ready", 32'(in_ready), 32'd1);

        // Flush after two beats; flush with in_valid in IDLE must not accept.
        push_beat(8, 1'b1, 1'b0, 4);
        push_beat(9, 1'b1, 1'b0, 3);
        send(32'h0000_0F00);
        @(posedge clk);
        @(posedge clk); #1;
        check("t4_two_beats_taken", 32'(exp_q.size()), 32'd0);
        flush = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_match = 32'h0000_0003;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t4_flush_no_valid", 32'(out_valid), 32'd0);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_after_flush_valid", 32'(out_valid), 32'd0);
        check("t4_after_flush_ready", 32'(in_ready), 32'd1);

        // Reset mid-drain discards index 7.
        push_beat(5, 1'b1, 1'b0, 2);
        send(32'h0000_00A0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t5_in_ready_after_rst", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t5_no_more_beats", 32'(out_valid), 32'd0);
        end

        check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_match_drain.md
CAM_MATCH_DRAIN -- requirements
Module: cam_match_drain

Interface
REQ-001 Parameters: none; depth fixed at 32 entries and index width at 5 bits, both taken from the shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 flush  input  1  synchronous abort of the current drain.
REQ-005 in_valid  input  1  match vector offered.
REQ-006 in_ready  output  1  block can accept a vector.
REQ-007 in_match  input  32  CAM match vector; bit i set means entry i hit.
REQ-008 out_valid  output  1  index beat valid.
REQ-009 out_ready  input  1  downstream accepts beat.
REQ-010 out_idx  output  5  matching entry index.
REQ-011 out_hit  output  1  1 = real match beat; 0 = miss beat.
REQ-012 out_last  output  1  final beat of the current vector.
REQ-013 out_remaining  output  6  matches left including the current beat (present only with MATCH_DRAIN_COUNT_EN).

Function
REQ-014 The block SHALL have two states, IDLE and DRAIN, plus a 32-bit pending register.
REQ-015 IDLE: in_ready=1 and out_valid=0; on in_valid&&in_ready the block SHALL load pending=in_match and enter DRAIN.
REQ-016 Latency: a vector accepted at edge n SHALL give out_valid=1 in the cycle after edge n (1 cycle); no combinational in->out path.
REQ-017 DRAIN: out_valid=1 and in_ready=0; out_idx SHALL be the lowest set bit of pending, out_hit=1, and out_last=1 iff pending has exactly one bit set.
REQ-018 On out_valid&&out_ready in DRAIN, the block SHALL clear bit out_idx of pending; if out_last=1 it returns to IDLE, otherwise it stays in DRAIN. Throughput: one index per cycle.
REQ-019 Zero vector: pending==0 in DRAIN SHALL produce one beat with out_hit=0, out_idx=0, out_last=1; that beat's handshake returns the block to IDLE.
REQ-020 Backpressure: while out_valid&&!out_ready, out_idx, out_hit, out_last and out_remaining SHALL hold stable.
REQ-021 in_ready SHALL first assert in the cycle after the last-beat handshake; accept and final beat never overlap.
REQ-022 flush=1 SHALL force IDLE and clear pending at the next edge from any state.
REQ-023 flush SHALL take priority over a simultaneous in_valid (no accept) and over a simultaneous out handshake (beat counts as taken, drain discarded).
REQ-024 All-ones vector SHALL drain as 32 beats with indices 0..31 ascending; only index 31 has out_last=1.

Reset
REQ-025 While rst=1, at the next edge: state=IDLE, pending=0; out_valid=0, in_ready=0 while rst asserted, out_idx=0, out_hit=0, out_last=0, out_remaining=0.
REQ-026 Reset mid-drain SHALL discard the pending vector with no further beats; in_ready=1 in the first cycle after rst deasserts.
REQ-027 rst SHALL take priority over flush and all handshakes.

Configuration
REQ-028 Macro MATCH_DRAIN_COUNT_EN defined: the out_remaining port and a population count of pending SHALL be present.
REQ-029 With MATCH_DRAIN_COUNT_EN: out_remaining is the popcount of pending in DRAIN (0 on a miss beat, 0 in IDLE).
REQ-030 Without the macro: the out_remaining port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 The shared package cam_pkg SHALL hold CAM_DEPTH=32, CAM_IDX_W=5, typedefs cam_match_t (32b) and cam_idx_t (5b), and the drain state enum.
REQ-032 Sub-module onehot_dec_5_32 (5-bit index to 32-bit one-hot) SHALL generate the pending clear mask; the lowest-set-bit encode SHALL be combinational from pending.

Verification
REQ-033 Accept 0x8000_0011, out_ready=1 -> beats idx 0,4,31; last on 31; out_remaining 3,2,1; in_ready high the cycle after.
REQ-034 Accept 0x0 -> single beat out_hit=0, out_idx=0, out_last=1; then IDLE.
REQ-035 Accept 0xFFFF_FFFF with out_ready toggling 1/0 -> 32 beats idx 0..31 in order, outputs stable during stalls, no beat lost or duplicated.
REQ-036 Accept 0x0000_0F00, flush after second beat -> beats 8,9 only; flush held with in_valid=1 in IDLE -> no accept.
REQ-037 Accept 0x0000_00A0, assert rst after first beat (idx 5) -> out_valid=0 next cycle, idx 7 never emitted; in_ready=1 after rst drops.
